// File: rtl/bayer_gray_binner_if.sv
// Pixel stream bundle for bayer_gray_binner: raw Bayer input side and gray/raw output side.
// master = upstream capture / test driver, slave = the binner itself.
interface bayer_gray_binner_if #(
  parameter int DATA_W  = 12,
  parameter int LINE_W  = 1280,
  parameter int FRAME_H = 960
);
  localparam int XW = $clog2(LINE_W);
  localparam int YW = $clog2(FRAME_H);

  logic              in_sof;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [XW-1:0]     out_x;
  logic [YW-1:0]     out_y;
  logic              frame_done;
  logic              sof_err;

  modport master (
    output in_sof, in_valid, in_data,
    input  out_valid, out_data, out_x, out_y, frame_done, sof_err
  );

  modport slave (
    input  in_sof, in_valid, in_data,
    output out_valid, out_data, out_x, out_y, frame_done, sof_err
  );
endinterface

// File: rtl/bayer_gray_binner.sv
// Streaming Bayer 2x2 binner (mean of each R/G1/G2/B quad) with runtime raw bypass.
// Define GRAY_ROUND_EN to round the quad mean half-up instead of truncating.
module bayer_gray_binner #(
  parameter int DATA_W  = 12,
  parameter int LINE_W  = 1280,
  parameter int FRAME_H = 960
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  bayer_gray_binner_if.slave   bus
);
  localparam int XW = $clog2(LINE_W);
  localparam int YW = $clog2(FRAME_H);
  localparam int SW = DATA_W + 2;

  localparam logic [XW-1:0] COL_LAST = XW'(LINE_W - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(FRAME_H - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] COMP = 2'd2;
  localparam logic [1:0] PASS = 2'd3;

  function automatic logic [DATA_W-1:0] gray_avg(input logic [SW-1:0] sum);
`ifdef GRAY_ROUND_EN
    return DATA_W'((sum + SW'(2)) >> 2);
`else
    return DATA_W'(sum >> 2);
`endif
  endfunction

  logic [1:0]        state_q, state_d;
  logic [XW-1:0]     col_q, col_d;
  logic [YW-1:0]     row_q, row_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] cur_prev_q, cur_prev_d;
  logic [DATA_W-1:0] top_prev_q, top_prev_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [XW-1:0]     out_x_q, out_x_d;
  logic [YW-1:0]     out_y_q, out_y_d;
  logic              frame_done_q, frame_done_d;
  logic              sof_err_q, sof_err_d;

  logic [DATA_W-1:0] linebuf [LINE_W];
  logic              lb_we;
  logic              last_px, restart, col_end, row_end;
  logic [1:0]        st;
  logic [XW-1:0]     c;
  logic [YW-1:0]     r;
  logic [SW-1:0]     sum;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    mode_d       = mode_q;
    cur_prev_d   = cur_prev_q;
    top_prev_d   = top_prev_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    frame_done_d = 1'b0;
    sof_err_d    = 1'b0;
    lb_we        = 1'b0;

    // A sof on the frame's final pixel completes that frame first; any other sof restarts at (0,0).
    last_px = (state_q == COMP || state_q == PASS) && col_q == COL_LAST && row_q == ROW_LAST;
    restart = bus.in_valid && bus.in_sof && !last_px;
    st      = restart ? (mode ? PASS : FILL) : state_q;
    c       = restart ? '0 : col_q;
    r       = restart ? '0 : row_q;
    col_end = (c == COL_LAST);
    row_end = (r == ROW_LAST);
    sum     = SW'(top_prev_q) + SW'(linebuf[c]) + SW'(cur_prev_q) + SW'(bus.in_data);

    if (restart) begin
      mode_d    = mode;
      sof_err_d = (state_q != IDLE);
    end

    if (bus.in_valid) begin
      if (st != IDLE) begin
        state_d = st;
        col_d   = col_end ? '0 : c + XW'(1);
        row_d   = r;
      end
      case (st)
        FILL: begin
          lb_we = 1'b1;
          if (col_end) begin
            row_d   = r + YW'(1);
            state_d = COMP;
          end
        end
        COMP: begin
          if (!c[0]) begin
            cur_prev_d = bus.in_data;
            top_prev_d = linebuf[c];
          end else begin
            out_valid_d  = 1'b1;
            out_data_d   = gray_avg(sum);
            out_x_d      = c >> 1;
            out_y_d      = r >> 1;
            frame_done_d = col_end && row_end;
          end
          if (col_end) begin
            row_d   = row_end ? '0 : r + YW'(1);
            state_d = row_end ? IDLE : FILL;
          end
        end
        PASS: begin
          out_valid_d  = 1'b1;
          out_data_d   = bus.in_data;
          out_x_d      = c;
          out_y_d      = r;
          frame_done_d = col_end && row_end;
          if (col_end) begin
            row_d   = row_end ? '0 : r + YW'(1);
            state_d = row_end ? IDLE : PASS;
          end
        end
        default: ;
      endcase
      if (bus.in_sof && last_px) begin
        state_d = mode ? PASS : FILL;
        mode_d  = mode;
        col_d   = '0;
        row_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      mode_q       <= mode_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
    end
  end

  // Data-only storage: a stale line is always overwritten by a FILL row before COMP reads it.
  always_ff @(posedge clk) begin
    cur_prev_q <= cur_prev_d;
    top_prev_q <= top_prev_d;
    if (lb_we) linebuf[c] <= bus.in_data;
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_x      = out_x_q;
  assign bus.out_y      = out_y_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sof_err    = sof_err_q;
endmodule

// File: tb/tb_bayer_gray_binner.sv
// Randomized bench for bayer_gray_binner against a frame-image reference model.
module tb_bayer_gray_binner;
  localparam int DW  = 12;
  localparam int LW  = 8;
  localparam int FH  = 4;
  localparam int NPX = LW * FH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic mode  = 1'b0;

  bayer_gray_binner_if #(.DATA_W(DW), .LINE_W(LW), .FRAME_H(FH)) bus ();

  bayer_gray_binner #(.DATA_W(DW), .LINE_W(LW), .FRAME_H(FH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int obs_out  = 0;
  int obs_fd   = 0;
  int obs_err  = 0;
  bit gaps     = 1'b0;

  // Reference model: frame position as a linear pixel index plus the raw image seen so far.
  bit m_in_frame = 1'b0;
  bit m_mode     = 1'b0;
  int m_n        = 0;
  int img [FH][LW];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit v, input bit s, input int d, input bit m);
    bit e_v = 1'b0, e_fd = 1'b0, e_err = 1'b0, last;
    int e_d = 0, e_x = 0, e_y = 0, x, y, sum, dd;
    dd = d & ((1 << DW) - 1);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = dd[DW-1:0];
    mode         = m;
    if (v) begin
      last = m_in_frame && (m_n == NPX - 1);
      if (s && !last) begin
        e_err      = m_in_frame;
        m_in_frame = 1'b1;
        m_n        = 0;
        m_mode     = m;
      end
      if (m_in_frame) begin
        x = m_n % LW;
        y = m_n / LW;
        img[y][x] = dd;
        if (m_mode) begin
          e_v = 1'b1; e_d = dd; e_x = x; e_y = y;
        end else if ((y % 2 == 1) && (x % 2 == 1)) begin
          sum = img[y-1][x-1] + img[y-1][x] + img[y][x-1] + dd;
`ifdef GRAY_ROUND_EN
          e_d = (sum + 2) / 4;
`else
          e_d = sum / 4;
`endif
          e_v = 1'b1; e_x = x / 2; e_y = y / 2;
        end
        e_fd = (m_n == NPX - 1);
        m_n++;
        if (m_n == NPX) m_in_frame = 1'b0;
      end
      if (s && last) begin
        m_in_frame = 1'b1;
        m_n        = 0;
        m_mode     = m;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", bus.out_valid, e_v);
    check("frame_done", bus.frame_done, e_fd);
    check("sof_err", bus.sof_err, e_err);
    if (e_v) begin
      check("out_data", bus.out_data, e_d);
      check("out_x", bus.out_x, e_x);
      check("out_y", bus.out_y, e_y);
    end
    if (bus.out_valid)  obs_out++;
    if (bus.frame_done) obs_fd++;
    if (bus.sof_err)    obs_err++;
  endtask

  task automatic send(input bit s, input int d, input bit m);
    if (gaps) repeat ($urandom_range(0, 2))
      cycle(1'b0, 1'(($urandom_range(0, 1))), int'($urandom), 1'(($urandom_range(0, 1))));
    cycle(1'b1, s, d, m);
  endtask

  task automatic rst_cycles(input int k);
    rst_n = 1'b0;
    repeat (k) begin
      bus.in_valid = 1'b1;
      bus.in_sof   = 1'(($urandom_range(0, 1)));
      bus.in_data  = DW'($urandom);
      @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_x", bus.out_x, 0);
      check("rst_out_y", bus.out_y, 0);
      check("rst_frame_done", bus.frame_done, 0);
      check("rst_sof_err", bus.sof_err, 0);
    end
    rst_n      = 1'b1;
    m_in_frame = 1'b0;
    m_n        = 0;
  endtask

  function automatic void clr_obs();
    obs_out = 0;
    obs_fd  = 0;
    obs_err = 0;
  endfunction

  initial begin
    int d;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;

    rst_cycles(3);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, int'($urandom), 1'b0);

    // Directed first quad, rest of frame random
    for (int i = 0; i < NPX; i++) begin
      d = (i == 0) ? 100 : (i == 1) ? 101 : (i == 8) ? 102 : (i == 9) ? 103 : int'($urandom);
      send(i == 0, d, 1'b0);
      if (i == 9) begin
`ifdef GRAY_ROUND_EN
        check("quad00_data", bus.out_data, 102);
`else
        check("quad00_data", bus.out_data, 101);
`endif
      end
    end

    // Saturated frame with input gaps
    gaps = 1'b1;
    clr_obs();
    for (int i = 0; i < NPX; i++) send(i == 0, 4095, 1'b0);
    check("full_out_count", obs_out, 8);
    check("full_fd_count", obs_fd, 1);

    // Bypass ramp, mode wiggled after sof
    clr_obs();
    for (int i = 0; i < NPX; i++) send(i == 0, i, (i == 0) ? 1'b1 : 1'(($urandom_range(0, 1))));
    check("pass_out_count", obs_out, NPX);
    check("pass_fd_count", obs_fd, 1);

    // Restart at row 2 col 3, then a complete new frame
    gaps = 1'b0;
    clr_obs();
    for (int i = 0; i < 2 * LW + 3; i++) send(i == 0, int'($urandom), 1'b0);
    for (int i = 0; i < NPX; i++) send(i == 0, int'($urandom), 1'b0);
    check("abort_err_count", obs_err, 1);
    check("abort_fd_count", obs_fd, 1);
    check("abort_out_count", obs_out, 12);

    // sof coincident with last pixel, then reset mid-row
    clr_obs();
    for (int i = 0; i < NPX; i++) send(i == 0 || i == NPX - 1, int'($urandom), 1'b0);
    check("coinc_fd_count", obs_fd, 1);
    check("coinc_err_count", obs_err, 0);
    for (int i = 0; i < 5; i++) send(1'b0, int'($urandom), 1'b0);
    rst_cycles(1);
    for (int i = 0; i < 10; i++) send(1'b0, int'($urandom), 1'b0);
    check("post_rst_out_count", obs_out, 8);

    // Random frames, random modes, occasional stray sof
    gaps = 1'b1;
    for (int k = 0; k < 240; k++)
      send((k % 40 == 0) || ($urandom_range(0, 59) == 0), int'($urandom), 1'(($urandom_range(0, 1))));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
